i2c_txn_sequencer: RTL and testbench
====================================

# i2c_txn_sequencer

Transaction front end that sits directly upstream of `i2c_master`. It accepts host transaction commands, buffers write bytes in a TX FIFO and read bytes in an RX FIFO, and drives the master's control and mode registers. It serves the master's `o_tx_data_needed` pulses from the TX FIFO, collects `o_rx_data_valid` bytes, and reports completion and error status back to the host.

## Interface
- `FIFO_DEPTH`, 16: entries per FIFO; must be a power of 2, at least 2.
- `START_TIMEOUT`, 1024: cycles allowed after START for the master's BUSY bit to rise.
- `i_clk` in 1: clock.
- `i_rst` in 1: reset; asynchronous, active-high.
- `i_cmd_valid` / `o_cmd_ready` in/out 1: command handshake.
- `i_cmd_addr` in 10: slave address; 7-bit mode uses [6:0].
- `i_cmd_len` in 8: byte count.
- `i_cmd_rd` in 1: 1 = read, 0 = write.
- `i_cmd_addr10` in 1: 1 = 10-bit addressing.
- `i_wr_valid` / `o_wr_ready` in/out 1, `i_wr_data` in 8: TX FIFO push.
- `o_rd_valid` / `i_rd_ready` out/in 1, `o_rd_data` out 8: RX FIFO pop; first-word-fall-through.
- `o_done` out 1: one-cycle pulse when a transaction ends.
- `o_err` out 3: sticky {timeout, overrun, master_err}. Cleared on the next command accept.
- `o_slave_addr` out 10, `o_byte_cnt` out 8: to master; held for the whole transaction.
- `o_control_reg` out 4: [3] start, [2] clear_status, [1:0] = 0.
- `o_mode_reg` out 4: [3] addr_mode, [2] rw_mode, [1:0] = 0.
- `o_tx_data` out 8: TX FIFO head, or 8'hFF when the FIFO is empty.
- `i_tx_data_needed` in 1, `i_rx_data_valid` in 1, `i_rx_data` in 8, `i_status_reg` in 5: from master. Status bits are [BUSY TX_DONE RX_DONE TX_ERR RX_ERR].

## Operation
- State machine states: IDLE, FILL, START, WAIT_BUSY, RUN, FINISH.
- IDLE:
  - `o_cmd_ready` = 1.
  - On accept, latch address, length, rd and addr10, and clear `o_err`.
  - If len = 0, go to FINISH without issuing START.
  - Otherwise go to FILL for writes and START for reads.
- FILL (write): wait until TX FIFO count ≥ min(len, FIFO_DEPTH), then go to START.
- START:
  - `o_control_reg[3]` = 1 for exactly one cycle.
  - For writes, pop the TX head in the same cycle; the master latches `o_tx_data` on start.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - When BUSY = 1, go to RUN.
  - After START_TIMEOUT cycles without BUSY, set the timeout bit and go to FINISH.
- RUN: when BUSY falls to 0, go to FINISH.
- FINISH:
  - If TX_ERR or RX_ERR is set, set master_err.
  - Pulse `o_done` and `o_control_reg[2]` for one cycle, then return to IDLE.
- TX serving, in any non-IDLE state:
  - A `i_tx_data_needed` pulse with the FIFO non-empty pops one entry.
  - A pulse with the FIFO empty sets overrun; `o_tx_data` reads 8'hFF.
- RX capture, in any state:
  - `i_rx_data_valid` with the FIFO not full pushes `i_rx_data`.
  - With the FIFO full, the byte is dropped and overrun is set.
- Host TX push is allowed in any state: `o_wr_ready` = !tx_full. Simultaneous push and pop on a full FIFO is legal and the count is unchanged.
- Reset mid-transaction:
  - Returns to IDLE and empties both FIFOs.
  - All outputs return to reset values; no `o_done` pulse is emitted.

## Timing
- Reset values:
  - `o_cmd_ready` = 1, `o_wr_ready` = 1.
  - `o_rd_valid`, `o_done`, `o_err` = 0.
  - All master-side outputs = 0, except `o_tx_data` = 8'hFF.
- Read command accepted at cycle N: START asserted at N+1.
- Write command with data already buffered, accepted at cycle N: FILL at N+1, START at N+2.
- `o_done` is asserted one cycle after the BUSY falling edge is sampled.
- FIFO push-to-visible latency: 1 cycle, from push to `o_rd_valid` / `o_tx_data`.
- Counters: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; counts are log2(FIFO_DEPTH)+1 bits. The timeout counter saturates.
- All outputs are registered except `o_cmd_ready`, `o_wr_ready`, `o_rd_valid`, `o_rd_data` and `o_tx_data`, which decode directly from state and FIFO state.

## Structure
- Shared package `i2c_pkg` holds:
  - Status masks (BUSY/TX_DONE/RX_DONE/TX_ERR/RX_ERR).
  - Control bit indices (START = 3, CLEAR = 2) and mode bit indices (ADDR_MODE = 3, RW = 2).
  - Sequencer state encoding and `o_err` bit indices.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH, first-word-fall-through, full/empty/count outputs) is instantiated twice, for TX and RX.

## Test plan
- Write, 7-bit: push 3A, 5C, 7E; command addr = 0x50, len = 3, wr.
  - One start pulse is issued with `o_mode_reg` = 4'b0000.
  - `o_tx_data` reads 3A at start, then 5C and 7E on two needed pulses.
  - `o_done` pulses with `o_err` = 0.
- Read, 10-bit: command addr = 0x2A5, len = 2, rd; master returns A1, B2.
  - `o_mode_reg` = 4'b1100.
  - RX pops yield A1 then B2.
  - `o_done` pulses once, coincident with clear_status.
- len = 0 command: no start pulse; `o_done` two cycles after accept.
- BUSY never asserted: timeout bit set after 1024 cycles; `o_done` pulses; next command accept clears `o_err`.
- TX underrun and RX overflow:
  - A needed pulse with the TX FIFO empty gives `o_tx_data` = FF and sets overrun.
  - 17 RX bytes with DEPTH = 16 and no pops drops the 17th byte and sets overrun.
- Assert `i_rst` during RUN: all outputs reach reset values within the same cycle, both FIFOs read empty, and there is no `o_done` pulse.

Source files
------------

// File: rtl/i2c_pkg.sv
// ============================================================================
//  Module  : i2c_pkg
//  Purpose : Shared definitions for the I2C transaction sequencer: master
//            status masks, control/mode register bit positions, sequencer
//            state encoding and error-flag bit positions.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    // Master status register layout: [4]=BUSY [3]=TX_DONE [2]=RX_DONE
    // [1]=TX_ERR [0]=RX_ERR
    localparam logic [4:0] c_ST_BUSY    = 5'b10000;
    localparam logic [4:0] c_ST_TX_DONE = 5'b01000;
    localparam logic [4:0] c_ST_RX_DONE = 5'b00100;
    localparam logic [4:0] c_ST_TX_ERR  = 5'b00010;
    localparam logic [4:0] c_ST_RX_ERR  = 5'b00001;

    // Master control register bit positions
    localparam int c_CTRL_START = 3;
    localparam int c_CTRL_CLEAR = 2;

    // Master mode register bit positions
    localparam int c_MODE_ADDR  = 3;
    localparam int c_MODE_RW    = 2;

    // Sticky error vector bit positions
    localparam int c_ERR_TIMEOUT = 2;
    localparam int c_ERR_OVERRUN = 1;
    localparam int c_ERR_MASTER  = 0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FILL      = 3'd1,
        S_START     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_RUN       = 3'd4,
        S_FINISH    = 3'd5
    } seq_state_t;

endpackage : i2c_pkg

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module  : sync_fifo
//  Purpose : Single-clock first-word-fall-through FIFO.  The head entry is
//            presented on o_data whenever o_empty is low.
//  Ports   : i_clk, i_rst (async, active-high)
//            i_push/i_data  - write side; a push while full is accepted only
//                             when a pop happens in the same cycle
//            i_pop          - removes the head entry (ignored when empty)
//            o_data         - head entry
//            o_full/o_empty/o_count - occupancy
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    // DEPTH is a power of two, so the count MSB alone marks "full".
    assign o_full  = r_count[c_AW];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
// ============================================================================
//  Module  : i2c_txn_sequencer
//  Purpose : Host-side transaction front end for i2c_master.  Buffers write
//            bytes (TX FIFO) and read bytes (RX FIFO), sequences START,
//            waits for the master's BUSY window and reports done/errors.
//  Ports   : i_clk, i_rst (async, active-high)
//            Host command : i_cmd_valid/o_cmd_ready, i_cmd_addr, i_cmd_len,
//                           i_cmd_rd, i_cmd_addr10
//            Host TX push : i_wr_valid/o_wr_ready, i_wr_data
//            Host RX pop  : o_rd_valid/i_rd_ready, o_rd_data (FWFT)
//            Status       : o_done (pulse), o_err {timeout,overrun,master_err}
//            Master side  : o_slave_addr, o_byte_cnt, o_control_reg,
//                           o_mode_reg, o_tx_data, i_tx_data_needed,
//                           i_rx_data_valid, i_rx_data, i_status_reg
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_txn_sequencer
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int START_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // host command
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [9:0]  i_cmd_addr,
    input  logic [7:0]  i_cmd_len,
    input  logic        i_cmd_rd,
    input  logic        i_cmd_addr10,
    // host TX push
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [7:0]  i_wr_data,
    // host RX pop
    output logic        o_rd_valid,
    input  logic        i_rd_ready,
    output logic [7:0]  o_rd_data,
    // host status
    output logic        o_done,
    output logic [2:0]  o_err,
    // master side
    output logic [9:0]  o_slave_addr,
    output logic [7:0]  o_byte_cnt,
    output logic [3:0]  o_control_reg,
    output logic [3:0]  o_mode_reg,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_data_needed,
    input  logic        i_rx_data_valid,
    input  logic [7:0]  i_rx_data,
    input  logic [4:0]  i_status_reg
);

    localparam int          c_AW      = $clog2(FIFO_DEPTH);
    localparam int          c_TW      = $clog2(START_TIMEOUT) + 1;
    localparam logic [31:0] c_DEPTH_U = FIFO_DEPTH;
    localparam logic [31:0] c_TO_LAST = START_TIMEOUT - 1;

    seq_state_t r_state;
    seq_state_t w_next;

    logic [9:0]      r_addr;
    logic [7:0]      r_len;
    logic            r_rd;
    logic            r_addr10;
    logic            r_start;
    logic            r_clear;
    logic            r_done;
    logic [2:0]      r_err;
    logic [c_TW-1:0] r_to_cnt;

    logic            w_accept;
    logic            w_busy;
    logic            w_xfer_err;
    logic            w_to_hit;
    logic            w_fill_ok;
    logic [31:0]     w_fill_target;
    logic [2:0]      w_err_set;

    logic            w_tx_push;
    logic            w_tx_pop;
    logic            w_tx_under;
    logic [7:0]      w_tx_head;
    logic            w_tx_full;
    logic            w_tx_empty;
    logic [c_AW:0]   w_tx_count;

    logic            w_rx_push;
    logic            w_rx_drop;
    logic            w_rx_full;
    logic            w_rx_empty;
    logic [c_AW:0]   w_rx_count_unused;

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    // Host push is qualified by o_wr_ready so a refused beat is never
    // captured behind the host's back when a pop frees a slot.
    assign w_tx_push  = i_wr_valid & ~w_tx_full;

    // START pops the head for writes: the master latches o_tx_data on
    // start, so later needed pulses must see the following byte.
    assign w_tx_pop   = ~w_tx_empty &
                        (((r_state == S_START) & ~r_rd) |
                         ((r_state != S_IDLE) & i_tx_data_needed));
    assign w_tx_under = (r_state != S_IDLE) & i_tx_data_needed & w_tx_empty;

    assign w_rx_push  = i_rx_data_valid & ~w_rx_full;
    assign w_rx_drop  = i_rx_data_valid & w_rx_full;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_tx_push),
        .i_data  (i_wr_data),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (w_tx_count)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_rx_push),
        .i_data  (i_rx_data),
        .i_pop   (i_rd_ready),
        .o_data  (o_rd_data),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (w_rx_count_unused)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    assign w_accept   = i_cmd_valid & (r_state == S_IDLE);
    assign w_busy     = |(i_status_reg & c_ST_BUSY);
    assign w_xfer_err = |(i_status_reg & (c_ST_TX_ERR | c_ST_RX_ERR));

    // Long writes cannot be fully buffered; start once the FIFO is full.
    assign w_fill_target = (32'(r_len) < c_DEPTH_U) ? 32'(r_len) : c_DEPTH_U;
    assign w_fill_ok     = (32'(w_tx_count) >= w_fill_target);

    // r_to_cnt counts completed WAIT_BUSY cycles; the last allowed cycle
    // without BUSY is the one where the count reaches START_TIMEOUT-1.
    assign w_to_hit = (r_state == S_WAIT_BUSY) & ~w_busy &
                      (32'(r_to_cnt) >= c_TO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_len == 8'd0) w_next = S_FINISH;
                    else if (i_cmd_rd)     w_next = S_START;
                    else                   w_next = S_FILL;
                end
            end
            S_FILL:      if (w_fill_ok) w_next = S_START;
            S_START:     w_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (w_busy)        w_next = S_RUN;
                else if (w_to_hit) w_next = S_FINISH;
            end
            S_RUN:       if (!w_busy) w_next = S_FINISH;
            S_FINISH:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_err_set                = '0;
        w_err_set[c_ERR_TIMEOUT] = w_to_hit;
        w_err_set[c_ERR_OVERRUN] = w_tx_under | w_rx_drop;
        w_err_set[c_ERR_MASTER]  = (r_state == S_FINISH) & w_xfer_err;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_rd     <= 1'b0;
            r_addr10 <= 1'b0;
            r_start  <= 1'b0;
            r_clear  <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= '0;
            r_to_cnt <= '0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_addr   <= i_cmd_addr10 ? i_cmd_addr : {3'b000, i_cmd_addr[6:0]};
                r_len    <= i_cmd_len;
                r_rd     <= i_cmd_rd;
                r_addr10 <= i_cmd_addr10;
            end

            // Start is high exactly while the FSM sits in START.
            r_start <= (w_next == S_START);
            // Done/clear follow FINISH by one cycle so that the master_err
            // sampled in FINISH is already visible alongside o_done.
            r_done  <= (r_state == S_FINISH);
            r_clear <= (r_state == S_FINISH);

            // A flag raised in the accept cycle itself survives the clear.
            r_err <= (w_accept ? 3'b000 : r_err) | w_err_set;

            if (r_state != S_WAIT_BUSY)
                r_to_cnt <= '0;
            else if (r_to_cnt != '1)
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_wr_ready   = ~w_tx_full;
    assign o_rd_valid   = ~w_rx_empty;
    assign o_tx_data    = w_tx_empty ? 8'hFF : w_tx_head;
    assign o_done       = r_done;
    assign o_err        = r_err;
    assign o_slave_addr = r_addr;
    assign o_byte_cnt   = r_len;

    always_comb begin
        o_control_reg               = '0;
        o_control_reg[c_CTRL_START] = r_start;
        o_control_reg[c_CTRL_CLEAR] = r_clear;
    end

    always_comb begin
        o_mode_reg              = '0;
        o_mode_reg[c_MODE_ADDR] = r_addr10;
        o_mode_reg[c_MODE_RW]   = r_rd;
    end

endmodule : i2c_txn_sequencer

`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
// ============================================================================
//  Module  : tb_i2c_txn_sequencer
//  Purpose : Self-checking bench for i2c_txn_sequencer with a behavioural
//            I2C master stand-in and queue-based expected data.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_txn_sequencer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [9:0] i_cmd_addr;
    logic [7:0] i_cmd_len;
    logic       i_cmd_rd;
    logic       i_cmd_addr10;
    logic       i_wr_valid;
    logic       o_wr_ready;
    logic [7:0] i_wr_data;
    logic       o_rd_valid;
    logic       i_rd_ready;
    logic [7:0] o_rd_data;
    logic       o_done;
    logic [2:0] o_err;
    logic [9:0] o_slave_addr;
    logic [7:0] o_byte_cnt;
    logic [3:0] o_control_reg;
    logic [3:0] o_mode_reg;
    logic [7:0] o_tx_data;
    logic       i_tx_data_needed;
    logic       i_rx_data_valid;
    logic [7:0] i_rx_data;
    logic [4:0] i_status_reg;

    i2c_txn_sequencer #(
        .FIFO_DEPTH    (16),
        .START_TIMEOUT (1024)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_cmd_valid      (i_cmd_valid),
        .o_cmd_ready      (o_cmd_ready),
        .i_cmd_addr       (i_cmd_addr),
        .i_cmd_len        (i_cmd_len),
        .i_cmd_rd         (i_cmd_rd),
        .i_cmd_addr10     (i_cmd_addr10),
        .i_wr_valid       (i_wr_valid),
        .o_wr_ready       (o_wr_ready),
        .i_wr_data        (i_wr_data),
        .o_rd_valid       (o_rd_valid),
        .i_rd_ready       (i_rd_ready),
        .o_rd_data        (o_rd_data),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_slave_addr     (o_slave_addr),
        .o_byte_cnt       (o_byte_cnt),
        .o_control_reg    (o_control_reg),
        .o_mode_reg       (o_mode_reg),
        .o_tx_data        (o_tx_data),
        .i_tx_data_needed (i_tx_data_needed),
        .i_rx_data_valid  (i_rx_data_valid),
        .i_rx_data        (i_rx_data),
        .i_status_reg     (i_status_reg)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt  = 0;

    logic [7:0] wq[$];   // bytes the host will write
    logic [7:0] rq[$];   // bytes the master model will return

    // Event counters observed on the inactive edge.
    always @(negedge i_clk) begin
        if (o_control_reg[3]) start_cnt++;
        if (o_done)           done_cnt++;
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [9:0] exp_addr(input logic [9:0] a, input logic a10);
        return a10 ? a : {3'b000, a[6:0]};
    endfunction

    task automatic send_cmd(input logic [9:0] a, input logic a10, input int len, input logic rd);
        i_cmd_valid  = 1'b1;
        i_cmd_addr   = a;
        i_cmd_addr10 = a10;
        i_cmd_len    = 8'(len);
        i_cmd_rd     = rd;
        tick;
        i_cmd_valid  = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", o_cmd_ready); end
        checks++; if (o_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", o_wr_ready); end
        checks++; if ({o_rd_valid, o_done, o_err} !== 5'b0) begin errors++; $display("FAIL reset_host_status: got %b want 00000", {o_rd_valid, o_done, o_err}); end
        checks++; if ({o_slave_addr, o_byte_cnt, o_control_reg, o_mode_reg} !== 26'b0) begin errors++; $display("FAIL reset_master_regs: got %h want 0", {o_slave_addr, o_byte_cnt, o_control_reg, o_mode_reg}); end
        checks++; if (o_tx_data !== 8'hFF) begin errors++; $display("FAIL reset_tx_data: got %h want FF", o_tx_data); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_write(input logic [9:0] a, input logic a10, input logic [1:0] merr);
        logic [7:0] exp[$];
        int len, k, s0, d0;
        exp = wq;
        len = exp.size();
        for (int i = 0; i < len; i++) begin
            i_wr_valid = 1'b1; i_wr_data = exp[i];
            tick;
        end
        i_wr_valid = 1'b0;
        s0 = start_cnt; d0 = done_cnt;
        checks++; if (o_cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_cmd_ready: got %b want 1", o_cmd_ready); end
        send_cmd(a, a10, len, 1'b0);
        k = 0;
        while (!o_control_reg[3] && k < 20) begin tick; k++; end
        checks++; if (k !== 1) begin errors++; $display("FAIL wr_start_latency: got %0d want 1 cycles after accept cycle+1", k); end
        checks++; if (o_mode_reg !== {a10, 1'b0, 2'b00}) begin errors++; $display("FAIL wr_mode: got %b want %b", o_mode_reg, {a10, 1'b0, 2'b00}); end
        checks++; if (o_slave_addr !== exp_addr(a, a10) || o_byte_cnt !== 8'(len)) begin errors++; $display("FAIL wr_addr_len: got %h/%0d want %h/%0d", o_slave_addr, o_byte_cnt, exp_addr(a, a10), len); end
        checks++; if (o_tx_data !== exp[0]) begin errors++; $display("FAIL wr_tx_at_start: got %h want %h", o_tx_data, exp[0]); end
        tick;
        i_status_reg = 5'b10000;
        tick;
        for (int i = 1; i < len; i++) begin
            checks++; if (o_tx_data !== exp[i]) begin errors++; $display("FAIL wr_tx_needed[%0d]: got %h want %h", i, o_tx_data, exp[i]); end
            i_tx_data_needed = 1'b1;
            tick;
            i_tx_data_needed = 1'b0;
            tick;
        end
        i_status_reg = {3'b000, merr};
        tick;
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL wr_done_early: got %b want 0", o_done); end
        tick;
        checks++; if (o_done !== 1'b1 || o_control_reg[2] !== 1'b1) begin errors++; $display("FAIL wr_done_clear: got done=%b clr=%b want 1/1", o_done, o_control_reg[2]); end
        checks++; if (o_err !== {2'b00, |merr}) begin errors++; $display("FAIL wr_err: got %b want %b", o_err, {2'b00, |merr}); end
        i_status_reg = 5'b0;
        tick;
        checks++; if (o_done !== 1'b0 || done_cnt - d0 !== 1 || start_cnt - s0 !== 1) begin errors++; $display("FAIL wr_pulse_counts: got done=%b dones=%0d starts=%0d want 0/1/1", o_done, done_cnt - d0, start_cnt - s0); end
        checks++; if (o_tx_data !== 8'hFF) begin errors++; $display("FAIL wr_tx_drained: got %h want FF", o_tx_data); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_read(input logic [9:0] a, input logic a10, input logic [1:0] merr);
        logic [7:0] exp[$];
        int len, k, d0;
        exp = rq;
        len = exp.size();
        d0 = done_cnt;
        send_cmd(a, a10, len, 1'b1);
        k = 0;
        while (!o_control_reg[3] && k < 20) begin tick; k++; end
        checks++; if (k !== 0) begin errors++; $display("FAIL rd_start_latency: got %0d want 0", k); end
        checks++; if (o_mode_reg !== {a10, 1'b1, 2'b00}) begin errors++; $display("FAIL rd_mode: got %b want %b", o_mode_reg, {a10, 1'b1, 2'b00}); end
        checks++; if (o_slave_addr !== exp_addr(a, a10) || o_byte_cnt !== 8'(len)) begin errors++; $display("FAIL rd_addr_len: got %h/%0d want %h/%0d", o_slave_addr, o_byte_cnt, exp_addr(a, a10), len); end
        tick;
        i_status_reg = 5'b10000;
        tick;
        for (int i = 0; i < len; i++) begin
            i_rx_data_valid = 1'b1; i_rx_data = exp[i];
            tick;
            i_rx_data_valid = 1'b0;
            tick;
        end
        i_status_reg = {3'b000, merr};
        tick;
        tick;
        checks++; if (o_done !== 1'b1 || o_control_reg[2] !== 1'b1) begin errors++; $display("FAIL rd_done_clear: got done=%b clr=%b want 1/1", o_done, o_control_reg[2]); end
        checks++; if (o_err !== {2'b00, |merr}) begin errors++; $display("FAIL rd_err: got %b want %b", o_err, {2'b00, |merr}); end
        i_status_reg = 5'b0;
        tick;
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rd_done_once: got %0d want 1", done_cnt - d0); end
        for (int i = 0; i < len; i++) begin
            checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp[i]) begin errors++; $display("FAIL rd_pop[%0d]: got v=%b %h want 1 %h", i, o_rd_valid, o_rd_data, exp[i]); end
            i_rd_ready = 1'b1;
            tick;
            i_rd_ready = 1'b0;
        end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_empty: got %b want 0", o_rd_valid); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_len_zero;
        int s0;
        s0 = start_cnt;
        send_cmd(10'h012, 1'b0, 0, 1'b0);
        checks++; if (o_done !== 1'b0 || o_err !== 3'b000) begin errors++; $display("FAIL len0_after_accept: got done=%b err=%b want 0/000", o_done, o_err); end
        tick;
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", o_done); end
        tick;
        checks++; if (start_cnt !== s0) begin errors++; $display("FAIL len0_no_start: got %0d starts want 0", start_cnt - s0); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout;
        int k;
        send_cmd(10'h033, 1'b0, 1, 1'b1);
        checks++; if (o_control_reg[3] !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", o_control_reg[3]); end
        k = 0;
        while (!o_done && k < 2000) begin tick; k++; end
        checks++; if (k < 1025 || k > 1027) begin errors++; $display("FAIL to_latency: got %0d want ~1026 cycles", k); end
        checks++; if (o_err !== 3'b100) begin errors++; $display("FAIL to_err: got %b want 100", o_err); end
        tick;
        test_len_zero();   // accept must clear the sticky timeout
    endtask

    // ------------------------------------------------------------------
    task automatic test_underrun;
        int k;
        wq = '{8'h5A};
        i_wr_valid = 1'b1; i_wr_data = 8'h5A;
        tick;
        i_wr_valid = 1'b0;
        send_cmd(10'h021, 1'b0, 1, 1'b0);
        k = 0;
        while (!o_control_reg[3] && k < 20) begin tick; k++; end
        tick;
        i_status_reg = 5'b10000;
        tick;
        checks++; if (o_tx_data !== 8'hFF) begin errors++; $display("FAIL under_tx_ff: got %h want FF", o_tx_data); end
        i_tx_data_needed = 1'b1;
        tick;
        i_tx_data_needed = 1'b0;
        checks++; if (o_err !== 3'b010) begin errors++; $display("FAIL under_overrun: got %b want 010", o_err); end
        i_status_reg = 5'b0;
        tick;
        tick;
        checks++; if (o_done !== 1'b1 || o_err !== 3'b010) begin errors++; $display("FAIL under_done: got done=%b err=%b want 1/010", o_done, o_err); end
        tick;
    endtask

    // ------------------------------------------------------------------
    task automatic test_rx_overflow;
        logic [7:0] exp[$];
        test_len_zero();
        for (int i = 0; i < 17; i++) exp.push_back(8'($urandom));
        for (int i = 0; i < 17; i++) begin
            i_rx_data_valid = 1'b1; i_rx_data = exp[i];
            tick;
            if (i == 15) begin
                checks++; if (o_err !== 3'b000 || o_rd_valid !== 1'b1) begin errors++; $display("FAIL ovf_16_ok: got err=%b v=%b want 000/1", o_err, o_rd_valid); end
            end
        end
        i_rx_data_valid = 1'b0;
        checks++; if (o_err !== 3'b010) begin errors++; $display("FAIL ovf_17_err: got %b want 010", o_err); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (o_rd_valid !== 1'b1 || o_rd_data !== exp[i]) begin errors++; $display("FAIL ovf_pop[%0d]: got v=%b %h want 1 %h", i, o_rd_valid, o_rd_data, exp[i]); end
            i_rd_ready = 1'b1;
            tick;
            i_rd_ready = 1'b0;
        end
        checks++; if (o_rd_valid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got v=%b want 0", o_rd_valid); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_run;
        int d0;
        send_cmd(10'h3C7, 1'b1, 2, 1'b1);
        tick;
        i_status_reg = 5'b10000;
        tick;
        i_tx_data_needed = 1'b1;          // underrun -> overrun flag
        i_rx_data_valid  = 1'b1; i_rx_data = 8'hC3;
        tick;
        i_tx_data_needed = 1'b0;
        i_rx_data_valid  = 1'b0;
        i_wr_valid = 1'b1; i_wr_data = 8'h77;
        tick;
        i_wr_valid = 1'b0;
        checks++; if (o_err !== 3'b010 || o_rd_valid !== 1'b1 || o_tx_data !== 8'h77 || o_cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_pre: got err=%b v=%b tx=%h rdy=%b want 010/1/77/0", o_err, o_rd_valid, o_tx_data, o_cmd_ready); end
        d0 = done_cnt;
        i_rst = 1'b1;
        #1;
        checks++; if (o_cmd_ready !== 1'b1 || o_wr_ready !== 1'b1 || o_rd_valid !== 1'b0 || o_done !== 1'b0 || o_err !== 3'b000) begin errors++; $display("FAIL rst_host: got rdy=%b wr=%b v=%b done=%b err=%b", o_cmd_ready, o_wr_ready, o_rd_valid, o_done, o_err); end
        checks++; if ({o_slave_addr, o_byte_cnt, o_control_reg, o_mode_reg} !== 26'b0 || o_tx_data !== 8'hFF) begin errors++; $display("FAIL rst_master: got %h tx=%h want 0 FF", {o_slave_addr, o_byte_cnt, o_control_reg, o_mode_reg}, o_tx_data); end
        tick;
        i_rst = 1'b0;
        i_status_reg = 5'b0;
        tick; tick; tick;
        checks++; if (done_cnt !== d0 || o_cmd_ready !== 1'b1 || o_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_no_done: got dones=%0d rdy=%b v=%b want 0/1/0", done_cnt - d0, o_cmd_ready, o_rd_valid); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random;
        logic [9:0] a;
        logic       a10, rd;
        logic [1:0] merr;
        int         len;
        for (int n = 0; n < 6; n++) begin
            a    = 10'($urandom);
            a10  = 1'($urandom);
            rd   = 1'($urandom);
            len  = int'($urandom_range(1, 6));
            merr = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            wq.delete(); rq.delete();
            for (int i = 0; i < len; i++) begin
                if (rd) rq.push_back(8'($urandom));
                else    wq.push_back(8'($urandom));
            end
            if (rd) test_read(a, a10, merr);
            else    test_write(a, a10, merr);
            tick;
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        i_rst = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_rd = 1'b0; i_cmd_addr10 = 1'b0;
        i_wr_valid = 1'b0; i_wr_data = '0; i_rd_ready = 1'b0;
        i_tx_data_needed = 1'b0; i_rx_data_valid = 1'b0; i_rx_data = '0; i_status_reg = '0;
        tick; tick;
        test_reset();
        i_rst = 1'b0;
        tick;

        wq = '{8'h3A, 8'h5C, 8'h7E};
        test_write(10'h050, 1'b0, 2'b00);
        tick;
        rq = '{8'hA1, 8'hB2};
        test_read(10'h2A5, 1'b1, 2'b00);
        tick;
        test_len_zero();
        test_timeout();
        test_underrun();
        test_rx_overflow();
        test_random();
        test_reset_mid_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_i2c_txn_sequencer

`default_nettype wire
